// File: rtl/agc_serial_pkg.sv
// Shared types and constants for the AGC serial receiver: FSM encodings, the
// packet header tag, slot numbering and the header validity check.
package agc_serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } byte_state_t;

    typedef enum logic [1:0] {
        WAIT_HDR = 2'd0,
        WAIT_HI  = 2'd1,
        WAIT_LO  = 2'd2
    } pkt_state_t;

    localparam logic [4:0] HDR_TAG = 5'b10100;

    localparam logic [2:0] SLOT_VERB = 3'd0;
    localparam logic [2:0] SLOT_NOUN = 3'd1;
    localparam logic [2:0] SLOT_G    = 3'd2;
    localparam logic [2:0] SLOT_M    = 3'd3;
    localparam logic [2:0] SLOT_RA   = 3'd4;
    localparam logic [2:0] SLOT_RB   = 3'd5;
    localparam int         NUM_SLOTS = 6;

    function automatic logic is_header(input logic [7:0] b);
        return (b[7:3] == HDR_TAG) && (b[2:0] <= SLOT_RB);
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 2-flop synchronizer, start/data/stop framing, 8N1 by
// default or 8E1 when AGC_SERIAL_RX_PARITY_EN is defined.
module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);
    import agc_serial_pkg::*;

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta_reg;
    logic             rx_sync_reg;
    logic             rx_prev_reg;
    byte_state_t      state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_reg;
    logic [7:0]       shift_reg;
    logic             brk_reg;
    logic             bit_tick;
`ifdef AGC_SERIAL_RX_PARITY_EN
    logic             par_bad_reg;
`endif

    assign bit_tick  = (cnt_reg == LAST_CNT);
    assign byte_data = shift_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_reg     <= '0;
            shift_reg   <= '0;
            brk_reg     <= 1'b0;
            byte_valid  <= 1'b0;
            frame_err   <= 1'b0;
`ifdef AGC_SERIAL_RX_PARITY_EN
            par_bad_reg <= 1'b0;
`endif
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
            byte_valid  <= 1'b0;
            frame_err   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rx_prev_reg && !rx_sync_reg) begin
                        state_reg <= START;
                        cnt_reg   <= '0;
                    end
                end
                START: begin
                    // A start bit that is high again by mid-bit was a glitch.
                    if (cnt_reg == HALF_CNT) begin
                        cnt_reg   <= '0;
                        bit_reg   <= '0;
                        state_reg <= rx_sync_reg ? IDLE : DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        cnt_reg   <= '0;
                        shift_reg <= {rx_sync_reg, shift_reg[7:1]};
                        bit_reg   <= bit_reg + 1'b1;
                        if (bit_reg == 3'd7) begin
`ifdef AGC_SERIAL_RX_PARITY_EN
                            state_reg <= PARITY;
`else
                            state_reg <= STOP;
`endif
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
`ifdef AGC_SERIAL_RX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        cnt_reg     <= '0;
                        par_bad_reg <= ^{shift_reg, rx_sync_reg};
                        state_reg   <= STOP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
`endif
                STOP: begin
                    // After a bad stop bit, hold here until the line is idle again.
                    if (brk_reg) begin
                        if (rx_sync_reg) begin
                            brk_reg   <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end else if (bit_tick) begin
                        cnt_reg <= '0;
                        if (!rx_sync_reg) begin
                            frame_err <= 1'b1;
                            brk_reg   <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
`ifdef AGC_SERIAL_RX_PARITY_EN
                            if (par_bad_reg) frame_err  <= 1'b1;
                            else             byte_valid <= 1'b1;
`else
                            byte_valid <= 1'b1;
`endif
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/agc_serial_rx.sv
// AGC input-word receiver: decodes 3-byte UART packets into six 15-bit words.
// Define AGC_SERIAL_RX_PARITY_EN for even-parity framing.
module agc_serial_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx,
    output logic [14:0] dsky_verb,
    output logic [14:0] dsky_noun,
    output logic [14:0] axi_g,
    output logic [14:0] axi_m,
    output logic [14:0] axi_ra,
    output logic [14:0] axi_rb,
    output logic        update_valid,
    output logic [2:0]  update_sel,
    output logic        rx_error
);
    import agc_serial_pkg::*;

    localparam int            TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int            TO_W     = $clog2(TO_LIMIT) + 1;
    localparam logic [TO_W-1:0] TO_END = TO_W'(TO_LIMIT);

    logic [7:0]      byte_data;
    logic            byte_valid;
    logic            frame_err;
    pkt_state_t      pkt_reg;
    logic [2:0]      sel_reg;
    logic [6:0]      hi_reg;
    logic [TO_W-1:0] to_cnt_reg;
    logic            commit;

    uart_byte_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx         (rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    assign commit = byte_valid && (pkt_reg == WAIT_LO);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pkt_reg      <= WAIT_HDR;
            sel_reg      <= '0;
            hi_reg       <= '0;
            to_cnt_reg   <= '0;
            update_valid <= 1'b0;
            update_sel   <= '0;
            rx_error     <= 1'b0;
        end else begin
            update_valid <= 1'b0;
            rx_error     <= 1'b0;
            if (pkt_reg == WAIT_HDR || byte_valid) to_cnt_reg <= '0;
            else                                   to_cnt_reg <= to_cnt_reg + 1'b1;

            // A framing error and a timeout both abort with a single error pulse.
            if (frame_err) begin
                rx_error <= 1'b1;
                pkt_reg  <= WAIT_HDR;
            end else if (byte_valid) begin
                case (pkt_reg)
                    WAIT_HDR: begin
                        if (is_header(byte_data)) begin
                            sel_reg <= byte_data[2:0];
                            pkt_reg <= WAIT_HI;
                        end else begin
                            rx_error <= 1'b1;
                        end
                    end
                    WAIT_HI: begin
                        if (byte_data[7]) begin
                            rx_error <= 1'b1;
                            if (is_header(byte_data)) sel_reg <= byte_data[2:0];
                            else                      pkt_reg <= WAIT_HDR;
                        end else begin
                            hi_reg  <= byte_data[6:0];
                            pkt_reg <= WAIT_LO;
                        end
                    end
                    WAIT_LO: begin
                        update_valid <= 1'b1;
                        update_sel   <= sel_reg;
                        pkt_reg      <= WAIT_HDR;
                    end
                    default: pkt_reg <= WAIT_HDR;
                endcase
            end else if (pkt_reg != WAIT_HDR && to_cnt_reg == TO_END) begin
                rx_error <= 1'b1;
                pkt_reg  <= WAIT_HDR;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_word
        logic [14:0] word_reg;
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n)                          word_reg <= '0;
            else if (commit && sel_reg == 3'(gi))  word_reg <= {hi_reg, byte_data};
        end
    end

    assign dsky_verb = g_word[SLOT_VERB].word_reg;
    assign dsky_noun = g_word[SLOT_NOUN].word_reg;
    assign axi_g     = g_word[SLOT_G].word_reg;
    assign axi_m     = g_word[SLOT_M].word_reg;
    assign axi_ra    = g_word[SLOT_RA].word_reg;
    assign axi_rb    = g_word[SLOT_RB].word_reg;

endmodule
